// File: rtl/pipe_reg_hs_pkg.sv
// Shared definitions for the elastic pipeline register.
// Holds the width helper used to size the occupancy counter.
package pipe_pkg;

  function automatic int cnt_w(input int stage);
    return $clog2(stage + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_hs_slot.sv
// One slot of the elastic pipeline: a valid flag plus data word.
// Loads from its predecessor whenever it can pass its content on or is empty.
module pipe_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  input  logic             next_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             load_s;

  // An empty slot always accepts, which is what collapses bubbles.
  assign ready  = next_ready | ~valid_r;
  assign load_s = ready & prev_valid & ~flush;
  assign valid  = valid_r;
  assign data   = data_r;

  // Valid flag: cleared by flush, otherwise follows the predecessor when ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (ready) begin
      valid_r <= prev_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data word: only captured for an incoming valid word; flush leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
    end else if (load_s) begin
      data_r <= prev_data;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/pipe_reg_hs.sv
// Elastic pipeline register: STAGE slots with valid/ready backpressure,
// bubble collapsing, synchronous flush and a registered occupancy count.
module pipe_reg_hs
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(STAGE)-1:0]   count
);

  localparam int CW = cnt_w(STAGE);

  logic [STAGE:0]   v_s;
  logic [WIDTH-1:0] d_s [STAGE+1];
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;

  assign v_s[0] = in_valid;
  assign d_s[0] = in_data;

  // Ready travels backwards through per-block nets so each link is a distinct signal.
  for (genvar i = 0; i < STAGE; i++) begin : g_slot
    logic ready_s;
    logic next_ready_s;

    if (i == STAGE - 1) begin : g_last
      assign next_ready_s = out_ready;
    end else begin : g_mid
      assign next_ready_s = g_slot[i+1].ready_s;
    end

    pipe_slot #(.WIDTH(WIDTH)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .prev_valid (v_s[i]),
      .prev_data  (d_s[i]),
      .next_ready (next_ready_s),
      .valid      (v_s[i+1]),
      .data       (d_s[i+1]),
      .ready      (ready_s)
    );
  end

  assign in_ready   = g_slot[0].ready_s & ~flush;
  assign out_valid  = v_s[STAGE];
  assign out_data   = d_s[STAGE];
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid & out_ready;
  assign count      = count_r;

  // Next occupancy from this cycle's input and output transfers.
  always_comb begin
    count_nxt_s = count_r;
    case ({in_xfer_s, out_xfer_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Occupancy counter; flush empties every slot so it returns to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (flush) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Self-checking bench for pipe_reg_hs: per-cycle vector table on STAGE=2,
// hand sequences on STAGE=1/3/4, and order/count scoreboards on every instance.
module tb_pipe_reg_hs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // STAGE=2 instance
  logic iv2 = 1'b0, or2 = 1'b0, fl2 = 1'b0, ir2, ov2;
  logic [7:0] id2 = 8'h00, od2;
  logic [1:0] cnt2;
  // STAGE=4 instance
  logic iv4 = 1'b0, or4 = 1'b0, fl4 = 1'b0, ir4, ov4;
  logic [7:0] id4 = 8'h00, od4;
  logic [2:0] cnt4;
  // STAGE=3 instance
  logic iv3 = 1'b0, or3 = 1'b0, fl3 = 1'b0, ir3, ov3;
  logic [7:0] id3 = 8'h00, od3;
  logic [1:0] cnt3;
  // STAGE=1 instance
  logic iv1 = 1'b0, or1 = 1'b0, fl1 = 1'b0, ir1, ov1;
  logic [7:0] id1 = 8'h00, od1;
  logic [0:0] cnt1;

  pipe_reg_hs #(.WIDTH(8), .STAGE(2)) u2 (.clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2),
    .in_ready(ir2), .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2));
  pipe_reg_hs #(.WIDTH(8), .STAGE(4)) u4 (.clk(clk), .rst(rst), .flush(fl4), .in_valid(iv4),
    .in_ready(ir4), .in_data(id4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .count(cnt4));
  pipe_reg_hs #(.WIDTH(8), .STAGE(3)) u3 (.clk(clk), .rst(rst), .flush(fl3), .in_valid(iv3),
    .in_ready(ir3), .in_data(id3), .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cnt3));
  pipe_reg_hs #(.WIDTH(8), .STAGE(1)) u1 (.clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1),
    .in_ready(ir1), .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboards: accepted words queued in order, popped on each output transfer.
  logic [7:0] q1[$], q2[$], q3[$], q4[$];

  always @(posedge rst) begin
    q1.delete(); q2.delete(); q3.delete(); q4.delete();
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("sb2_count", int'(cnt2), q2.size());
      if (ov2 && or2) begin
        if (q2.size() == 0) chk("sb2_spurious_out", 1, 0);
        else chk("sb2_order", int'(od2), int'(q2.pop_front()));
      end
      if (fl2) q2.delete(); else if (iv2 && ir2) q2.push_back(id2);

      chk("sb4_count", int'(cnt4), q4.size());
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("sb4_spurious_out", 1, 0);
        else chk("sb4_order", int'(od4), int'(q4.pop_front()));
      end
      if (fl4) q4.delete(); else if (iv4 && ir4) q4.push_back(id4);

      chk("sb3_count", int'(cnt3), q3.size());
      if (ov3 && or3) begin
        if (q3.size() == 0) chk("sb3_spurious_out", 1, 0);
        else chk("sb3_order", int'(od3), int'(q3.pop_front()));
      end
      if (fl3) q3.delete(); else if (iv3 && ir3) q3.push_back(id3);

      chk("sb1_count", int'(cnt1), q1.size());
      if (ov1 && or1) begin
        if (q1.size() == 0) chk("sb1_spurious_out", 1, 0);
        else chk("sb1_order", int'(od1), int'(q1.pop_front()));
      end
      if (fl1) q1.delete(); else if (iv1 && ir1) q1.push_back(id1);
    end
  end

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       fl;
    logic       eir;
    logic       eov;
    logic [7:0] eod;
    logic [1:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                              input logic eir, input logic eov, input logic [7:0] eod, input logic [1:0] ecnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.eir = eir; v.eov = eov; v.eod = eod; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl[19];
  int   acc;

  initial begin
    //              iv    d      or    fl    ir    ov    od      cnt
    tbl[0]  = mk(1'b1, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  2'd0);
    tbl[1]  = mk(1'b1, 8'd1,  1'b1, 1'b0, 1'b1, 1'b0, 8'd0,  2'd1);
    tbl[2]  = mk(1'b1, 8'd2,  1'b1, 1'b0, 1'b1, 1'b1, 8'd0,  2'd2);
    tbl[3]  = mk(1'b1, 8'd3,  1'b1, 1'b0, 1'b1, 1'b1, 8'd1,  2'd2);
    tbl[4]  = mk(1'b1, 8'd4,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2,  2'd2);
    tbl[5]  = mk(1'b1, 8'd4,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2,  2'd2);
    tbl[6]  = mk(1'b1, 8'd4,  1'b0, 1'b0, 1'b0, 1'b1, 8'd2,  2'd2);
    tbl[7]  = mk(1'b1, 8'd4,  1'b1, 1'b0, 1'b1, 1'b1, 8'd2,  2'd2);
    tbl[8]  = mk(1'b1, 8'd5,  1'b1, 1'b0, 1'b1, 1'b1, 8'd3,  2'd2);
    tbl[9]  = mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'd4,  2'd2);
    tbl[10] = mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'd5,  2'd1);
    tbl[11] = mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd5,  2'd0);
    tbl[12] = mk(1'b1, 8'd9,  1'b0, 1'b0, 1'b1, 1'b0, 8'd5,  2'd0);
    tbl[13] = mk(1'b1, 8'd10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5,  2'd1);
    tbl[14] = mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd5,  2'd0);
    tbl[15] = mk(1'b1, 8'd20, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5,  2'd0);
    tbl[16] = mk(1'b1, 8'd21, 1'b1, 1'b0, 1'b1, 1'b0, 8'd5,  2'd1);
    tbl[17] = mk(1'b1, 8'd22, 1'b1, 1'b1, 1'b0, 1'b1, 8'd20, 2'd2);
    tbl[18] = mk(1'b0, 8'd0,  1'b1, 1'b0, 1'b1, 1'b0, 8'd20, 2'd0);

    // Reset state
    @(negedge clk);
    chk("rst_ov", int'(ov2), 0); chk("rst_od", int'(od2), 0);
    chk("rst_cnt", int'(cnt2), 0); chk("rst_ir", int'(ir2), 1);
    chk("rst_ov4", int'(ov4), 0); chk("rst_ir4", int'(ir4), 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // STAGE=2 streaming, backpressure and flush vectors
    for (int i = 0; i < 19; i++) begin
      iv2 = tbl[i].iv; id2 = tbl[i].d; or2 = tbl[i].ordy; fl2 = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", i), int'(ir2), int'(tbl[i].eir));
      chk($sformatf("row%0d_out_valid", i), int'(ov2), int'(tbl[i].eov));
      chk($sformatf("row%0d_out_data", i), int'(od2), int'(tbl[i].eod));
      chk($sformatf("row%0d_count", i), int'(cnt2), int'(tbl[i].ecnt));
      @(posedge clk); #1;
    end
    iv2 = 1'b0; fl2 = 1'b0;

    // STAGE=1: one-cycle latency, full throughput
    or1 = 1'b1; iv1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      id1 = 8'(k);
      @(negedge clk);
      chk("s1_in_ready", int'(ir1), 1);
      chk("s1_out_valid", int'(ov1), (k > 0) ? 1 : 0);
      chk("s1_count", int'(cnt1), (k > 0) ? 1 : 0);
      if (k > 0) chk("s1_out_data", int'(od1), k - 1);
      @(posedge clk); #1;
    end
    or1 = 1'b0;
    @(negedge clk);
    chk("s1_stall_in_ready", int'(ir1), 0);
    chk("s1_stall_out_data", int'(od1), 9);
    @(posedge clk); #1;
    or1 = 1'b1; iv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // STAGE=4 bubble collapse
    or4 = 1'b0; iv4 = 1'b1; id4 = 8'hA1;
    @(negedge clk); chk("bub_ir_a1", int'(ir4), 1);
    @(posedge clk); #1;
    iv4 = 1'b0;
    repeat (2) begin
      @(negedge clk); chk("bub_ir_idle", int'(ir4), 1);
      @(posedge clk); #1;
    end
    iv4 = 1'b1; id4 = 8'hA2;
    @(negedge clk); chk("bub_ir_a2", int'(ir4), 1);
    @(posedge clk); #1;
    iv4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bub_ov", int'(ov4), 1); chk("bub_od", int'(od4), 8'hA1);
    chk("bub_cnt", int'(cnt4), 2); chk("bub_ir_two_held", int'(ir4), 1);
    @(posedge clk); #1;
    iv4 = 1'b1; id4 = 8'hB0; acc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ir4) begin
        acc++;
        @(posedge clk); #1;
        id4 = id4 + 8'd1;
      end else begin
        break;
      end
    end
    chk("bub_extra_accepts", acc, 2);
    chk("bub_full_cnt", int'(cnt4), 4);
    chk("bub_full_od", int'(od4), 8'hA1);
    @(posedge clk); #1;
    iv4 = 1'b0; or4 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bub_drained_cnt", int'(cnt4), 0); chk("bub_drained_ov", int'(ov4), 0);
    @(posedge clk); #1;

    // STAGE=3 flush while full and stalled
    or3 = 1'b0; iv3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id3 = 8'(5 + k);
      @(negedge clk); chk("fl_fill_ir", int'(ir3), 1);
      @(posedge clk); #1;
    end
    id3 = 8'd8; fl3 = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", int'(ir3), 0); chk("fl_pre_ov", int'(ov3), 1);
    chk("fl_pre_od", int'(od3), 5); chk("fl_pre_cnt", int'(cnt3), 3);
    @(posedge clk); #1;
    fl3 = 1'b0; iv3 = 1'b0; or3 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("fl_post_ov", int'(ov3), 0); chk("fl_post_cnt", int'(cnt3), 0);
      @(posedge clk); #1;
    end
    chk("fl_post_od_held", int'(od3), 5);

    // STAGE=2 random traffic against the scoreboard
    for (int k = 0; k < 300; k++) begin
      iv2 = 1'($urandom_range(0, 1));
      or2 = 1'($urandom_range(0, 1));
      id2 = 8'($urandom_range(0, 255));
      fl2 = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    fl2 = 1'b0; iv2 = 1'b0; or2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rand_drain_queue", q2.size(), 0);
    chk("rand_drain_ov", int'(ov2), 0);
    @(posedge clk); #1;

    // Async reset mid-stream
    iv2 = 1'b1; id2 = 8'h33; or2 = 1'b0;
    iv1 = 1'b1; id1 = 8'h44; or1 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("arst_pre_ov", int'(ov2), 1);
    rst = 1'b1;
    #1;
    chk("arst_ov", int'(ov2), 0); chk("arst_od", int'(od2), 0);
    chk("arst_cnt", int'(cnt2), 0); chk("arst_ir", int'(ir2), 1);
    chk("arst_ov1", int'(ov1), 0); chk("arst_od1", int'(od1), 0);
    chk("arst_cnt1", int'(cnt1), 0);
    rst = 1'b0;
    id2 = 8'h40; or2 = 1'b1; iv1 = 1'b0; or1 = 1'b1;
    @(negedge clk); chk("arst_restart_ov0", int'(ov2), 0);
    @(posedge clk); #1;
    iv2 = 1'b0;
    @(negedge clk); chk("arst_restart_ov1", int'(ov2), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_restart_ov2", int'(ov2), 1);
    chk("arst_restart_od", int'(od2), 8'h40);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg_hs.md
# pipe_reg_hs

Parametrised elastic pipeline register: the successor to the plain `shift_reg` delay line, adding valid/ready backpressure, bubble collapsing, synchronous flush and an occupancy count. It carries `WIDTH`-bit words through `STAGE` register slots. It sits between datapath stages of the encoder (e.g. float multiplier → quantiser), where the downstream consumer can stall.

## Interface
- `WIDTH`, default 8: data word width in bits, ≥1.
- `STAGE`, default 2: number of register slots (= latency when unstalled), ≥1.
- `clk`  input  1: clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `flush`  input  1: synchronous clear of all slots.
- `in_valid`  input  1: upstream word present.
- `in_ready`  output  1: pipeline accepts the word this cycle.
- `in_data`  input  WIDTH: upstream word.
- `out_valid`  output  1: last slot holds a valid word.
- `out_ready`  input  1: downstream accepts this cycle.
- `out_data`  output  WIDTH: last slot's word.
- `count`  output  $clog2(STAGE+1): number of valid slots.

## Operation
- Slots 0..STAGE-1 each hold `v[i]` and `d[i]`. Slot 0 is fed by the input; slot STAGE-1 drives the output.
- Per-slot ready:
  - `r[STAGE-1] = out_ready | ~v[STAGE-1]`.
  - `r[i] = r[i+1] | ~v[i]` for the other slots.
  - `in_ready = r[0] & ~flush`.
  - An empty slot always accepts, so bubbles collapse.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- When `r[i]` = 1, slot i loads from its predecessor (or the input for slot 0):
  - `v[i] <= v[i-1]`, or `<= in_valid` for slot 0.
  - `d[i]` loads only if the incoming valid is 1; otherwise `d[i]` holds.
- When `r[i]` = 0, slot i holds `v` and `d` (stall).
- `flush` = 1: all `v[i] <= 0` next edge. The input is not accepted, even if `in_valid` is 1. `d` holds.
- `count` is registered: next value = current count + input transfer − output transfer. On flush, next value = 0.
- `out_data` = `d[STAGE-1]`, `out_valid` = `v[STAGE-1]`. Both are registered, with no combinational path from input.
- Ordering: words leave in acceptance order. There is no duplication or loss except on flush.

## Timing
- Reset (async assert, sync release): all `v` = 0, all `d` = 0, `count` = 0, `out_valid` = 0, `out_data` = 0. `in_ready` = 1 once reset is asserted, unless `flush` is high.
- Latency: a word accepted at edge N appears on `out_valid`/`out_data` after edge N+STAGE-1. That is STAGE cycles from the accepting edge through STAGE registers, provided `out_ready` stays 1.
- Throughput: 1 word/cycle while `out_ready` = 1.
- Full: with all STAGE slots valid and `out_ready` = 0, `in_ready` = 0 and contents are frozen.
- Full with `out_ready` = 1: simultaneous accept and release; `count` is unchanged.
- Empty with `in_valid` = 0: `count` stays 0 and `out_valid` stays 0.
- `flush` together with an output transfer: the downstream still sees that transfer in the current cycle; all slots are empty the next cycle.
- `rst` mid-stream: all slots are discarded immediately; there is no partial state.
- Ready is a combinational chain from `out_ready` to `in_ready` with depth STAGE. This is accepted; there is no combinational valid→ready dependency.

## Structure
- Shared package `pipe_pkg` holds the count-width helper function `cnt_w(stage) = $clog2(stage+1)`.
- Sub-module `pipe_slot` (WIDTH) contains one slot's `v`/`d` registers and load/hold/flush logic. It has inputs `prev_valid`, `prev_data`, `next_ready`, `flush` and outputs `valid`, `data`, `ready`. The top level instantiates it STAGE times in a generate loop and adds the counter.

## Test plan
- **Streaming:** WIDTH=8, STAGE=2, `out_ready`=1, `in_valid`=1, `in_data` counting 0,1,2… from the cycle after reset. Required: `out_data` = 0 two cycles after first acceptance, then 1,2,3 consecutively, and `count` = 2 in steady state.
- **Backpressure:** same stream with `out_ready`=0 for 4 cycles. Required: `in_ready` falls after 2 accepts, `count` = 2, and `out_data` holds 0. After release the output resumes 0,1,2… with no gap, loss or duplicate.
- **Bubble collapse:** STAGE=4, `out_ready`=0, inject words 0xA1 and (after 2 idle cycles) 0xA2. Required: both occupy slots 3 and 2, `count` = 2, and `in_ready` stays 1 until 4 words are held.
- **Flush:** STAGE=3 full with 5,6,7 and `out_ready`=0; assert `flush` with `in_valid`=1, `in_data`=8. Required: `in_ready`=0 that cycle, then `out_valid`=0 and `count`=0; 8 never appears.
- **Async reset mid-stream:** pulse `rst` between clock edges while full. Required: `out_valid`, `out_data` and `count` go to 0 without waiting for an edge; streaming restarts cleanly.
- **Degenerate STAGE=1:** simultaneous accept/release each cycle. Required: 1-cycle latency, full throughput, `count` ∈ {0,1}.
